// File: rtl/riscv_v_pkg.sv
// Shared vector-unit constants and the writeback entry record.
package riscv_v_pkg;

   localparam int RISCV_V_DATA_WIDTH     = 128;
   localparam int RISCV_V_NUM_BYTES_DATA = RISCV_V_DATA_WIDTH / 8;
   localparam int RISCV_V_VREG_IDX_W     = 5;

   // One buffered ALU result on its way to the vector register file.
   typedef struct packed {
      logic [RISCV_V_DATA_WIDTH-1:0]     data;
      logic [RISCV_V_VREG_IDX_W-1:0]     vd;
      logic [RISCV_V_NUM_BYTES_DATA-1:0] byte_en;
      logic [RISCV_V_NUM_BYTES_DATA-1:0] zf;
      logic [RISCV_V_NUM_BYTES_DATA-1:0] of;
      logic [RISCV_V_NUM_BYTES_DATA-1:0] cf;
   } riscv_v_wb_entry_t;

   localparam int RISCV_V_WB_ENTRY_W = $bits(riscv_v_wb_entry_t);

   // Skid-buffer state; the encoding doubles as the occupancy count.
   typedef enum logic [1:0] {
      SKID_EMPTY = 2'd0,
      SKID_ONE   = 2'd1,
      SKID_TWO   = 2'd2
   } riscv_v_skid_state_e;

endpackage

// File: rtl/riscv_v_skid_buffer.sv
// Two-register skid buffer with a registered in_ready. The main register
// drives the output. The skid register catches the one entry that arrives
// while the consumer stalls.
module riscv_v_skid_buffer
   import riscv_v_pkg::*;
#(
   parameter int W = RISCV_V_WB_ENTRY_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   input  logic         flush,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic [1:0]   occupancy
);

   riscv_v_skid_state_e state;
   logic [W-1:0]        main_q;
   logic [W-1:0]        skid_q;
   logic                in_ready_q;
   logic                accept;
   logic                pop;

   assign accept    = in_valid & in_ready_q;
   assign pop       = out_valid & out_ready;
   assign out_valid = (state != SKID_EMPTY);
   assign out_data  = main_q;
   assign in_ready  = in_ready_q;
   assign occupancy = state;

   // FIFO state machine: moves entries between main/skid and keeps in_ready registered.
   always_ff @(posedge clk) begin
      // NOTE: all state here is written with <= so every register samples pre-edge values.
      if (rst) begin
         state      <= SKID_EMPTY;
         // NOTE: the data registers are reset too, so wb_* read as zero right after reset.
         main_q     <= '0;
         skid_q     <= '0;
         in_ready_q <= 1'b1;
      end else if (flush) begin
         // A same-cycle pop has already completed downstream; the accept is discarded.
         state      <= SKID_EMPTY;
         in_ready_q <= 1'b1;
      end else begin
         case (state)
            SKID_EMPTY: begin
               if (accept) begin
                  main_q <= in_data;
                  state  <= SKID_ONE;
               end
            end
            SKID_ONE: begin
               if (accept && pop) begin
                  main_q <= in_data;
               end else if (accept) begin
                  skid_q     <= in_data;
                  state      <= SKID_TWO;
                  in_ready_q <= 1'b0;
               end else if (pop) begin
                  state <= SKID_EMPTY;
               end
            end
            SKID_TWO: begin
               // in_ready is low here, so only a pop can happen.
               if (pop) begin
                  main_q     <= skid_q;
                  state      <= SKID_ONE;
                  in_ready_q <= 1'b1;
               end
            end
            default: begin
               state      <= SKID_EMPTY;
               in_ready_q <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/riscv_v_arith_wb_stage.sv
// Vector arithmetic writeback stage. It filters out results that have no
// enabled bytes and masks the flags with byte_en. It buffers entries in a
// 2-deep skid buffer toward the register-file write port and keeps the
// sticky overflow summary.
module riscv_v_arith_wb_stage
   import riscv_v_pkg::*;
#(
   parameter int DATA_WIDTH = RISCV_V_DATA_WIDTH,
   parameter int NUM_BYTES  = RISCV_V_NUM_BYTES_DATA,
   parameter int VREG_IDX_W = RISCV_V_VREG_IDX_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [NUM_BYTES-1:0]  in_zf,
   input  logic [NUM_BYTES-1:0]  in_of,
   input  logic [NUM_BYTES-1:0]  in_cf,
   input  logic [VREG_IDX_W-1:0] in_vd,
   input  logic [NUM_BYTES-1:0]  in_byte_en,
   input  logic                  flush,
   input  logic                  clr_sticky,
   output logic                  wb_valid,
   input  logic                  wb_ready,
   output logic [DATA_WIDTH-1:0] wb_data,
   output logic [VREG_IDX_W-1:0] wb_vd,
   output logic [NUM_BYTES-1:0]  wb_byte_en,
   output logic [NUM_BYTES-1:0]  wb_zf,
   output logic [NUM_BYTES-1:0]  wb_of,
   output logic [NUM_BYTES-1:0]  wb_cf,
   output logic                  of_sticky,
   output logic [1:0]            occupancy
);

   riscv_v_wb_entry_t in_entry;
   riscv_v_wb_entry_t wb_entry;
   logic              buf_in_valid;
   logic              accept;

   // Results with no enabled byte are consumed here and never enter the buffer.
   assign buf_in_valid = in_valid & (|in_byte_en);
   assign accept       = buf_in_valid & in_ready;

   // Build the entry, with flags masked down to the bytes actually written.
   always_comb begin
      in_entry         = '0;
      in_entry.data    = in_data;
      in_entry.vd      = in_vd;
      in_entry.byte_en = in_byte_en;
      in_entry.zf      = in_zf & in_byte_en;
      in_entry.of      = in_of & in_byte_en;
      in_entry.cf      = in_cf & in_byte_en;
   end

   riscv_v_skid_buffer #(
      .W (RISCV_V_WB_ENTRY_W)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (buf_in_valid),
      .in_ready  (in_ready),
      .in_data   (in_entry),
      .flush     (flush),
      .out_valid (wb_valid),
      .out_ready (wb_ready),
      .out_data  (wb_entry),
      .occupancy (occupancy)
   );

   assign wb_data    = wb_entry.data;
   assign wb_vd      = wb_entry.vd;
   assign wb_byte_en = wb_entry.byte_en;
   assign wb_zf      = wb_entry.zf;
   assign wb_of      = wb_entry.of;
   assign wb_cf      = wb_entry.cf;

   // Sticky overflow: a new accepted overflow wins over a same-cycle clear; flush has no effect.
   always_ff @(posedge clk) begin
      if (rst) begin
         of_sticky <= 1'b0;
      end else begin
         of_sticky <= (of_sticky & ~clr_sticky) | (accept & (|(in_of & in_byte_en)));
      end
   end

endmodule
